wasm_cmp_stack: RTL and testbench

- Parametrised successor to the core's single-opcode i32.eq path: an operand stack plus a multi-cycle comparison executor.
- Covers all WebAssembly integer test/compare opcodes for i32 and i64 (0x45–0x5A).
- Pops operands, compares, and pushes the i32 result (0/1) back.
- Sits beside the core decoder, which feeds it constants via the push port and compare opcodes via the op port.
- Exposes result / result_empty / trap with the same meaning as the core's outputs.

---
 rtl/wasm_cmp_stack.sv | 192 +++++++++++++++++++
 tb/tb_wasm_cmp_stack.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wasm_cmp_stack.sv
// wasm_cmp_stack: operand stack with a multi-cycle executor for the
// WebAssembly integer test/compare opcodes 0x45..0x5A (i32 and i64).
// A compare pops its operand(s), evaluates the flag and pushes an i32 0/1
// result back onto the stack.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   push_valid/push_data     push request and value; push_ready accepts it
//   op_valid/opcode          compare request and opcode; op_ready accepts it
//   done                     one-cycle pulse after the result has been pushed
//   result/result_empty      registered top of stack (0 when empty) / empty flag
//   depth                    current entry count
//   trap                     0 none, 1 underflow, 2 overflow, 3 invalid opcode
module wasm_cmp_stack #(
    parameter int DEPTH  = 16,
    parameter int DW     = 64,
    parameter int TRAP_W = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_valid,
    input  logic [DW-1:0]              push_data,
    output logic                       push_ready,
    input  logic                       op_valid,
    input  logic [7:0]                 opcode,
    output logic                       op_ready,
    output logic                       done,
    output logic [DW-1:0]              result,
    output logic                       result_empty,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic [TRAP_W-1:0]          trap
);

    localparam int SPW = $clog2(DEPTH+1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {IDLE, POP_B, POP_A, EXEC, PUSH, TRAP} state_t;

    state_t              state, state_next;
    logic [DW-1:0]       mem [DEPTH];
    logic [SPW-1:0]      sp;
    logic [TRAP_W-1:0]   trap_next;
    logic                push_take;
    logic                op_go;
    logic [7:0]          op_q;
    logic [DW-1:0]       a, b;
    logic                flag;
    logic [AW-1:0]       top_idx, below_idx, wr_idx;
    logic [DW-1:0]       top, below;

    function automatic logic is_eqz(input logic [7:0] op);
        return (op == 8'h45) || (op == 8'h50);
    endfunction

    function automatic logic is_cmp_op(input logic [7:0] op);
        return (op >= 8'h45) && (op <= 8'h5A);
    endfunction

    // i32 forms compare only the low words: sign- or zero-extend them to
    // 64 bits so both widths share one set of comparators.
    function automatic logic cmp_flag(input logic [7:0] op,
                                      input logic [63:0] x,
                                      input logic [63:0] y);
        logic               is64;
        logic [7:0]         off;
        logic [63:0]        xu, yu;
        logic signed [63:0] xs, ys;
        logic               f;
        is64 = (op >= 8'h50);
        off  = op - (is64 ? 8'h51 : 8'h46);
        xu   = is64 ? x : {32'h0, x[31:0]};
        yu   = is64 ? y : {32'h0, y[31:0]};
        xs   = is64 ? x : {{32{x[31]}}, x[31:0]};
        ys   = is64 ? y : {{32{y[31]}}, y[31:0]};
        f    = 1'b0;
        if (is_eqz(op)) begin
            f = (yu == 64'h0);
        end else begin
            case (off)
                8'd0:    f = (xu == yu);
                8'd1:    f = (xu != yu);
                8'd2:    f = (xs <  ys);
                8'd3:    f = (xu <  yu);
                8'd4:    f = (xs >  ys);
                8'd5:    f = (xu >  yu);
                8'd6:    f = (xs <= ys);
                8'd7:    f = (xu <= yu);
                8'd8:    f = (xs >= ys);
                8'd9:    f = (xu >= yu);
                default: f = 1'b0;
            endcase
        end
        return f;
    endfunction

    assign top_idx    = AW'(sp - SPW'(1));
    assign below_idx  = AW'(sp - SPW'(2));
    assign wr_idx     = AW'(sp);
    assign top        = mem[top_idx];
    assign below      = mem[below_idx];

    assign push_ready = (state == IDLE) && (trap == '0);
    assign op_ready   = (state == IDLE) && (trap == '0) && !push_valid;
    assign depth      = sp;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        trap_next  = trap;
        push_take  = 1'b0;
        op_go      = 1'b0;
        case (state)
            IDLE: begin
                if (push_valid && push_ready) begin
                    if (sp == SPW'(DEPTH)) begin
                        trap_next  = TRAP_W'(2);
                        state_next = TRAP;
                    end else begin
                        push_take = 1'b1;
                    end
                end else if (op_valid && op_ready) begin
                    if (!is_cmp_op(opcode)) begin
                        trap_next  = TRAP_W'(3);
                        state_next = TRAP;
                    end else if (sp < (is_eqz(opcode) ? SPW'(1) : SPW'(2))) begin
                        trap_next  = TRAP_W'(1);
                        state_next = TRAP;
                    end else begin
                        op_go      = 1'b1;
                        state_next = POP_B;
                    end
                end
            end
            POP_B:   state_next = is_eqz(op_q) ? EXEC : POP_A;
            POP_A:   state_next = EXEC;
            EXEC:    state_next = PUSH;
            PUSH:    state_next = IDLE;
            TRAP:    state_next = TRAP;
            default: state_next = IDLE;
        endcase
    end

    // Control and observable outputs: result tracks the new top every time sp moves
    always_ff @(posedge clk) begin
        if (reset) begin
            sp           <= '0;
            result       <= '0;
            result_empty <= 1'b1;
            trap         <= '0;
            done         <= 1'b0;
        end else begin
            trap <= trap_next;
            done <= (state == PUSH);
            if (push_take) begin
                sp           <= sp + SPW'(1);
                result       <= push_data;
                result_empty <= 1'b0;
            end
            if ((state == POP_B) || (state == POP_A)) begin
                sp           <= sp - SPW'(1);
                result       <= (sp >= SPW'(2)) ? below : '0;
                result_empty <= (sp == SPW'(1));
            end
            if (state == PUSH) begin
                sp           <= sp + SPW'(1);
                result       <= {{(DW-1){1'b0}}, flag};
                result_empty <= 1'b0;
            end
        end
    end

    // Operand capture and flag evaluation
    always_ff @(posedge clk) begin
        if (op_go)           op_q <= opcode;
        if (state == POP_B)  b    <= top;
        if (state == POP_A)  a    <= top;
        if (state == EXEC)   flag <= cmp_flag(op_q, a[63:0], b[63:0]);
    end

    // Stack storage; a reset edge suppresses any write in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (push_take)           mem[wr_idx] <= push_data;
            else if (state == PUSH)  mem[wr_idx] <= {{(DW-1){1'b0}}, flag};
        end
    end

endmodule

// File: tb/tb_wasm_cmp_stack.sv
// Bench for wasm_cmp_stack: table of compare vectors plus hand-written
// sequences for traps, overflow, push/op contention and reset mid-op.
module tb_wasm_cmp_stack;

    localparam int DEPTH  = 16;
    localparam int DW     = 64;
    localparam int TRAP_W = 4;
    localparam int SPW    = $clog2(DEPTH+1);
    localparam int NV     = 24;

    logic              clk = 1'b0;
    logic              reset;
    logic              push_valid;
    logic [DW-1:0]     push_data;
    logic              push_ready;
    logic              op_valid;
    logic [7:0]        opcode;
    logic              op_ready;
    logic              done;
    logic [DW-1:0]     result;
    logic              result_empty;
    logic [SPW-1:0]    depth;
    logic [TRAP_W-1:0] trap;

    wasm_cmp_stack #(.DEPTH(DEPTH), .DW(DW), .TRAP_W(TRAP_W)) dut (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
        .op_valid(op_valid), .opcode(opcode), .op_ready(op_ready),
        .done(done), .result(result), .result_empty(result_empty),
        .depth(depth), .trap(trap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { logic [63:0] val; int cyc; } sb_t;
    sb_t sb_q[$];
    sb_t mon_e;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [7:0]  op;
        logic        unary;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, expected done=0", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("done_result", result, mon_e.val);
                chk("done_latency", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; push_valid = 1'b0; op_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        sb_q.delete();
    endtask

    task automatic do_push(input logic [63:0] d);
        @(negedge clk);
        push_valid = 1'b1; push_data = d;
        #1;
        for (int i = 0; i < 20 && !push_ready; i++) begin
            @(negedge clk); #1;
        end
        if (!push_ready) begin
            n_checks++; n_fail++;
            $display("FAIL push_ready_timeout: got push_ready=0, expected 1");
        end
        @(posedge clk); #1;
        push_valid = 1'b0;
    endtask

    task automatic do_op(input logic [7:0] op, input bit expect_result,
                         input logic [63:0] exp, input int lat);
        sb_t e;
        @(negedge clk);
        op_valid = 1'b1; opcode = op;
        #1;
        for (int i = 0; i < 20 && !op_ready; i++) begin
            @(negedge clk); #1;
        end
        if (!op_ready) begin
            n_checks++; n_fail++;
            $display("FAIL op_ready_timeout: got op_ready=0, expected 1");
        end else if (expect_result) begin
            e.val = exp;
            e.cyc = cyc + 1 + lat;
            sb_q.push_back(e);
        end
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb_q.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        chk("scoreboard_drain", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{64'd5, 64'd5, 8'h46, 1'b0, 64'd1};
        vecs[1]  = '{64'hFFFF_FFFF_0000_0003, 64'd3, 8'h46, 1'b0, 64'd1};
        vecs[2]  = '{64'hFFFF_FFFF_0000_0003, 64'd3, 8'h51, 1'b0, 64'd0};
        vecs[3]  = '{64'hFFFF_FFFF, 64'd1, 8'h48, 1'b0, 64'd1};
        vecs[4]  = '{64'hFFFF_FFFF, 64'd1, 8'h49, 1'b0, 64'd0};
        vecs[5]  = '{64'd7, 64'd9, 8'h47, 1'b0, 64'd1};
        vecs[6]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 8'h53, 1'b0, 64'd1};
        vecs[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 8'h54, 1'b0, 64'd0};
        vecs[8]  = '{64'h8000_0000, 64'h7FFF_FFFF, 8'h4A, 1'b0, 64'd0};
        vecs[9]  = '{64'h8000_0000, 64'h7FFF_FFFF, 8'h4B, 1'b0, 64'd1};
        vecs[10] = '{64'd5, 64'd5, 8'h4C, 1'b0, 64'd1};
        vecs[11] = '{64'd6, 64'd5, 8'h4D, 1'b0, 64'd0};
        vecs[12] = '{64'hFFFF_FFFE, 64'hFFFF_FFFF, 8'h4E, 1'b0, 64'd0};
        vecs[13] = '{64'd3, 64'd3, 8'h4F, 1'b0, 64'd1};
        vecs[14] = '{64'd1, 64'h8000_0000_0000_0000, 8'h55, 1'b0, 64'd1};
        vecs[15] = '{64'd1, 64'h8000_0000_0000_0000, 8'h56, 1'b0, 64'd0};
        vecs[16] = '{64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFB, 8'h57, 1'b0, 64'd1};
        vecs[17] = '{64'd10, 64'd2, 8'h58, 1'b0, 64'd0};
        vecs[18] = '{64'd0, 64'd1, 8'h59, 1'b0, 64'd0};
        vecs[19] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 8'h5A, 1'b0, 64'd1};
        vecs[20] = '{64'h1_0000_0000, 64'd0, 8'h52, 1'b0, 64'd1};
        vecs[21] = '{64'h1_0000_0000, 64'd0, 8'h47, 1'b0, 64'd0};
        vecs[22] = '{64'd0, 64'h1_0000_0000, 8'h45, 1'b1, 64'd1};
        vecs[23] = '{64'd0, 64'h1_0000_0000, 8'h50, 1'b1, 64'd0};

        reset = 1'b1; push_valid = 1'b0; push_data = '0; op_valid = 1'b0; opcode = '0;
        repeat (3) @(negedge clk);
        chk("reset_depth", 64'(depth), 64'd0);
        chk("reset_result", result, 64'd0);
        chk("reset_empty", 64'(result_empty), 64'd1);
        chk("reset_trap", 64'(trap), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        reset = 1'b0;

        // Table of compare vectors, each from a clean stack
        for (int i = 0; i < NV; i++) begin
            do_reset();
            if (!vecs[i].unary) do_push(vecs[i].a);
            do_push(vecs[i].b);
            do_op(vecs[i].op, 1'b1, vecs[i].exp, vecs[i].unary ? 3 : 4);
            drain();
            @(negedge clk);
            chk($sformatf("vec%0d_result", i), result, vecs[i].exp);
            chk($sformatf("vec%0d_depth", i), 64'(depth), 64'd1);
            chk($sformatf("vec%0d_empty", i), 64'(result_empty), 64'd0);
            chk($sformatf("vec%0d_trap", i), 64'(trap), 64'd0);
        end

        // Two eqz ops in a row reuse the previous result
        do_reset();
        do_push(64'd0);
        do_op(8'h45, 1'b1, 64'd1, 3);
        drain();
        chk("eqz1_depth", 64'(depth), 64'd1);
        do_op(8'h45, 1'b1, 64'd0, 3);
        drain();
        chk("eqz2_result", result, 64'd0);
        chk("eqz2_depth", 64'(depth), 64'd1);

        // Compare on an empty stack underflows and locks up
        do_reset();
        do_op(8'h46, 1'b0, 64'd0, 0);
        chk("uflow_trap", 64'(trap), 64'd1);
        chk("uflow_result", result, 64'd0);
        chk("uflow_empty", 64'(result_empty), 64'd1);
        repeat (3) @(negedge clk);
        push_valid = 1'b1; push_data = 64'd7;
        #1;
        chk("uflow_push_ready", 64'(push_ready), 64'd0);
        push_valid = 1'b0; op_valid = 1'b1; opcode = 8'h46;
        #1;
        chk("uflow_op_ready", 64'(op_ready), 64'd0);
        @(negedge clk);
        op_valid = 1'b0;
        chk("uflow_depth_frozen", 64'(depth), 64'd0);
        chk("uflow_trap_sticky", 64'(trap), 64'd1);

        // Invalid opcode is reported ahead of underflow
        do_reset();
        do_op(8'h20, 1'b0, 64'd0, 0);
        chk("badop_trap", 64'(trap), 64'd3);
        chk("badop_depth", 64'(depth), 64'd0);

        // Fill to DEPTH, then overflow
        do_reset();
        for (int i = 0; i < DEPTH; i++) do_push(64'(i * 3 + 1));
        @(negedge clk);
        chk("full_depth", 64'(depth), 64'(DEPTH));
        chk("full_trap", 64'(trap), 64'd0);
        chk("full_result", result, 64'((DEPTH - 1) * 3 + 1));
        do_push(64'hDEAD);
        chk("oflow_trap", 64'(trap), 64'd2);
        chk("oflow_depth", 64'(depth), 64'(DEPTH));
        chk("oflow_result", result, 64'((DEPTH - 1) * 3 + 1));
        chk("oflow_push_ready", 64'(push_ready), 64'd0);

        // Push and op in the same IDLE cycle: push wins
        do_reset();
        do_push(64'd1);
        @(negedge clk);
        push_valid = 1'b1; push_data = 64'hAB; op_valid = 1'b1; opcode = 8'h46;
        #1;
        chk("contend_op_ready", 64'(op_ready), 64'd0);
        chk("contend_push_ready", 64'(push_ready), 64'd1);
        @(posedge clk); #1;
        push_valid = 1'b0; op_valid = 1'b0;
        chk("contend_depth", 64'(depth), 64'd2);
        chk("contend_result", result, 64'hAB);
        repeat (6) @(negedge clk);
        chk("contend_depth_after", 64'(depth), 64'd2);

        // Reset while the op sits in EXEC
        do_reset();
        do_push(64'd2);
        do_push(64'd2);
        do_op(8'h46, 1'b0, 64'd0, 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rstexec_done", 64'(done), 64'd0);
        chk("rstexec_result", result, 64'd0);
        chk("rstexec_depth", 64'(depth), 64'd0);
        chk("rstexec_empty", 64'(result_empty), 64'd1);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("rstexec_depth_after", 64'(depth), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
